bin_to_bcd_serial: RTL
======================

Name: bin_to_bcd_serial

Overview:
Sequential double-dabble converter: binary value in, packed BCD digits out. One bit is processed per clock.
Sits directly upstream of the two-digit hex/7-segment multiplexer. bcd[7:0] drives that display's 8-bit digit input, so it shows decimal rather than hex.
start/busy/done handshake. Result is held stable between conversions so the display never sees partial values.

Parameters:
IN_WIDTH, 8, width of binary input; also the conversion length in shift cycles
DIGITS, 3, number of BCD digits produced (4*DIGITS output bits)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
start  input  1  request conversion of bin; honoured only when idle
bin  input  IN_WIDTH  binary value; sampled only on the accepting edge
busy  output  1  conversion in progress
done  output  1  one-cycle pulse: bcd/overflow just updated
bcd  output  4*DIGITS  packed BCD, digit 0 in [3:0]; held until next done
overflow  output  1  value >= 10^DIGITS; held with bcd

Behaviour:
- Reset (async, any time incl. mid-conversion):
  - state=IDLE; busy=0, done=0, bcd=0, overflow=0.
  - Shift register and bit counter cleared; an in-flight conversion is abandoned, with no done.
- FSM states: IDLE, SHIFT.
- IDLE:
  - If start=1 at edge k: load bin into the binary shift register, clear the BCD work register, clear the overflow work flag, counter=0, go to SHIFT.
  - busy=1 from edge k.
- SHIFT, each edge:
  - First, every 4-bit work digit >=5 gets +3, all digits in parallel.
  - Then {work_bcd, bin_shreg} shifts left by 1.
  - The bit shifted out of the top digit ORs into the overflow work flag.
  - counter increments.
- Completion at edge k+IN_WIDTH (the IN_WIDTH-th shift):
  - bcd <= adjusted/shifted work register; overflow <= work flag.
  - done=1 for exactly that one cycle; busy=0; state=IDLE.
- Latency: done high in the cycle following edge k+IN_WIDTH (8 cycles after start for the default).
- busy is high on exactly IN_WIDTH consecutive cycles per conversion.
- start while busy: ignored; no queueing, bin not resampled.
- start high during the done cycle: accepted (state is IDLE). Back-to-back throughput is one conversion per IN_WIDTH+1 cycles.
- start held high continuously: repeated conversions, each re-sampling bin.
- Overflow (IN_WIDTH too wide for DIGITS):
  - bcd = value mod 10^DIGITS; overflow=1.
  - The work register is exactly 4*DIGITS bits wide, so higher bits are discarded, never wrapped.
- Outputs are registered; no combinational path from start/bin to any output.
- Counter width: clog2(IN_WIDTH+1). Add-3 is on a 4-bit nibble; the result never exceeds 4 bits since the input is at most 9.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SHIFT)
  - BCD_ADJ_THRESH=5 and BCD_ADJ_ADD=3
  - function/constant for counter width
- One natural sub-module: bcd_digit_adjust. Combinational, 4-bit in/out, +3 when >=5. Instantiated DIGITS times via generate.

Test Plan:
- Reset then idle: no start for 20 cycles -> busy=0, done=0, bcd=0x000, overflow=0 throughout.
- bin=8'd255, start 1 cycle at edge k -> busy high 8 cycles; done single pulse after edge k+8; bcd=12'h255, overflow=0. Same flow for bin=0 -> 12'h000 and bin=99 -> 12'h099.
- start pulsed again at k+3 with bin changed to 8'd7 during a 255 conversion -> ignored; result still 12'h255, exactly one done.
- start held high with bin=42 then 17 -> done every 9 cycles; bcd 12'h042 then 12'h017; bcd unchanged between done pulses.
- DIGITS=2 instance, bin=200 -> bcd=8'h00, overflow=1. bin=99 -> bcd=8'h99, overflow=0.
- Assert reset at k+4 mid-conversion -> all outputs 0 immediately (async); no done; next start with bin=128 -> bcd=12'h128 after 8 cycles.

Source files
------------

// File: rtl/bin_to_bcd_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_serial_pkg
// Description : Shared types and constants for the serial double-dabble
//               binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
package bin_to_bcd_serial_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

    // Counter must be able to hold IN_WIDTH itself.
    function automatic int cnt_width(input int in_width);
        return $clog2(in_width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adjust
// Description : Double-dabble nibble correction: add 3 when digit >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
    import bin_to_bcd_serial_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Input never exceeds 9, so the sum always fits in 4 bits.
    always_comb begin
        if (i_digit >= 4'(BCD_ADJ_THRESH)) begin
            o_digit = i_digit + 4'(BCD_ADJ_ADD);
        end else begin
            o_digit = i_digit;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_serial.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_serial
// Description : Serial double-dabble converter, one input bit per clock,
//               with start/busy/done handshake and held result.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_serial
    import bin_to_bcd_serial_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = cnt_width(IN_WIDTH);

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   bin_sr_q, bin_sr_d;
    logic [BCD_W-1:0]      work_q, work_d;
    logic                  ovf_work_q, ovf_work_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;

    logic [BCD_W-1:0]      work_adj;
    logic [BCD_W-1:0]      work_shift;
    logic [IN_WIDTH-1:0]   bin_shift;
    logic                  ovf_next;
    logic                  last_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit_adj
        bcd_digit_adjust u_adj (
            .i_digit (work_q[4*g +: 4]),
            .o_digit (work_adj[4*g +: 4])
        );
    end

    // Bits leaving the top digit are discarded from the result but flag overflow.
    assign work_shift = {work_adj[BCD_W-2:0], bin_sr_q[IN_WIDTH-1]};
    assign bin_shift  = {bin_sr_q[IN_WIDTH-2:0], 1'b0};
    assign ovf_next   = ovf_work_q | work_adj[BCD_W-1];
    assign last_shift = (cnt_q == CNT_W'(IN_WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_sr_q   <= '0;
            work_q     <= '0;
            ovf_work_q <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_sr_q   <= bin_sr_d;
            work_q     <= work_d;
            ovf_work_q <= ovf_work_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = SHIFT;
            SHIFT:   if (last_shift) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        bin_sr_d   = bin_sr_q;
        work_d     = work_q;
        ovf_work_d = ovf_work_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_sr_d   = bin;
                    work_d     = '0;
                    ovf_work_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            SHIFT: begin
                bin_sr_d   = bin_shift;
                work_d     = work_shift;
                ovf_work_d = ovf_next;
                cnt_d      = cnt_q + CNT_W'(1);
                if (last_shift) begin
                    bcd_d      = work_shift;
                    overflow_d = ovf_next;
                    done_d     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy     = (state_q == SHIFT);
        done     = done_q;
        bcd      = bcd_q;
        overflow = overflow_q;
    end

endmodule
`default_nettype wire
